// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared segment patterns and digit index type for the BCD display scanner.
package bcd_disp_pkg;
    localparam int N_DIGITS = 3;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    typedef logic [1:0] idx_t;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: nibble to active-low {g,f,e,d,c,b,a} pattern; non-BCD nibbles show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    logic [6:0] pat;
    always_comb begin
        pat = SEG_DASH;
        unique case (nibble_i)
            4'd0: pat = SEG_0;
            4'd1: pat = SEG_1;
            4'd2: pat = SEG_2;
            4'd3: pat = SEG_3;
            4'd4: pat = SEG_4;
            4'd5: pat = SEG_5;
            4'd6: pat = SEG_6;
            4'd7: pat = SEG_7;
            4'd8: pat = SEG_8;
            4'd9: pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        seg_o = blank_i ? SEG_BLANK : pat;
    end
endmodule

// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: 3-digit multiplexed 7-segment driver, new values swapped in only at frame ends.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_7seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);
    logic [CNT_W-1:0] presc_q, presc_d;
    idx_t             idx_q, idx_d;
    logic [11:0]      pend_q, pend_d, shadow_q, shadow_d;
    logic             pflag_q, pflag_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             fd_q, fd_d;
    logic             tick, wrap, load, blank;
    logic [3:0]       nib;

    always_comb begin
        tick     = enable && (presc_q == CNT_W'(CLK_DIV - 1));
        wrap     = tick && (idx_q == 2'd2);
        presc_d  = (!enable || tick) ? '0 : presc_q + 1'b1;
        idx_d    = (!enable || wrap) ? '0 : (tick ? idx_q + 1'b1 : idx_q);
        // While blanked there is nothing to tear, so pending is taken over at once.
        load     = pflag_q && (wrap || !enable);
        shadow_d = load ? pend_q : shadow_q;
        pend_d   = bcd_valid ? bcd : pend_q;
        pflag_d  = bcd_valid || (pflag_q && !load);
        fd_d     = wrap;
        an_d     = enable ? ~(3'b001 << idx_q) : 3'b111;
        nib      = (idx_q == 2'd2) ? shadow_q[11:8] : (idx_q == 2'd1) ? shadow_q[7:4] : shadow_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        blank    = !enable || (idx_q == 2'd2 && shadow_q[11:8] == 4'd0)
                           || (idx_q == 2'd1 && shadow_q[11:4] == 8'd0);
`else
        blank    = !enable;
`endif
    end

    bcd_to_seg7 u_dec (
        .nibble_i (nib),
        .blank_i  (blank),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            shadow_q <= '0;
            an_q     <= 3'b111;
            seg_q    <= SEG_BLANK;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// tb_bcd_7seg_scanner: vector table, corner sequences and random stimulus against a frame-level model.
module tb_bcd_7seg_scanner;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 3 * CLK_DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [6:0] ZH = LZB ? 7'h7F : 7'h40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] bcd = '0;
    logic        bcd_valid = 1'b0;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int total = 0;
    int passed = 0;

    bcd_7seg_scanner #(.CLK_DIV(CLK_DIV), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bcd(bcd), .bcd_valid(bcd_valid),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference: a single position counter within the frame; digit = pos / CLK_DIV.
    int          pos;
    logic [11:0] m_pend, m_shadow;
    bit          m_pf, m_fd;
    logic [2:0]  m_an;
    logic [6:0]  m_seg;

    function automatic logic [6:0] exp_seg(input logic [11:0] s, input int d);
        logic [3:0] nib;
        nib = 4'((s >> (4 * d)) & 12'hF);
        if (LZB && ((d == 2 && (s >> 8) == 0) || (d == 1 && (s >> 4) == 0))) return 7'h7F;
        return DEC[nib];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; m_pend = '0; m_shadow = '0; m_pf = 0;
            m_an = 3'b111; m_seg = 7'h7F; m_fd = 0;
        end else begin
            if (enable) begin
                m_an  = ~(3'b001 << (pos / CLK_DIV));
                m_seg = exp_seg(m_shadow, pos / CLK_DIV);
                m_fd  = (pos == FRAME - 1);
                if (pos == FRAME - 1 && m_pf) begin m_shadow = m_pend; m_pf = 0; end
                pos = (pos + 1) % FRAME;
            end else begin
                m_an = 3'b111; m_seg = 7'h7F; m_fd = 0; pos = 0;
                if (m_pf) begin m_shadow = m_pend; m_pf = 0; end
            end
            if (bcd_valid) begin m_pend = bcd; m_pf = 1; end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step(input bit en, input bit v, input logic [11:0] b);
        enable = en; bcd_valid = v; bcd = b;
        @(posedge clk);
        @(negedge clk);
        chk("model", 32'({an, seg, frame_done}), 32'({m_an, m_seg, m_fd}));
    endtask

    task automatic grab_frame(output logic [6:0] g2, output logic [6:0] g1, output logic [6:0] g0);
        g2 = 'x; g1 = 'x; g0 = 'x;
        for (int i = 0; i < FRAME; i++) begin
            step(1, 0, 12'h000);
            if (an == 3'b110) g0 = seg;
            if (an == 3'b101) g1 = seg;
            if (an == 3'b011) g2 = seg;
        end
    endtask

    typedef struct { logic [11:0] v; logic [6:0] s2, s1, s0; } vec_t;
    vec_t tbl [9];

    initial begin
        logic [6:0] g2, g1, g0;
        int n;
        bit found;
        tbl[0] = '{12'h259, 7'h24, 7'h12, 7'h10};
        tbl[1] = '{12'h000, ZH,    ZH,    7'h40};
        tbl[2] = '{12'h0AF, ZH,    7'h3F, 7'h3F};
        tbl[3] = '{12'h005, ZH,    ZH,    7'h12};
        tbl[4] = '{12'h987, 7'h10, 7'h00, 7'h78};
        tbl[5] = '{12'h346, 7'h30, 7'h19, 7'h02};
        tbl[6] = '{12'h0B0, ZH,    7'h3F, 7'h40};
        tbl[7] = '{12'h100, 7'h79, 7'h40, 7'h40};
        tbl[8] = '{12'h010, ZH,    7'h79, 7'h40};

        @(negedge clk);
        chk("reset_out", 32'({an, seg, frame_done}), 32'({3'b111, 7'h7F, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        // First frame still shows the reset shadow (000), then 259 appears.
        step(1, 1, 12'h259);
        for (int i = 0; i < FRAME - 1; i++) begin
            step(1, 0, 12'h000);
            if (an != 3'b111) chk("first_frame_seg", 32'(seg), 32'(exp_seg(12'h000, an == 3'b110 ? 0 : an == 3'b101 ? 1 : 2)));
        end
        grab_frame(g2, g1, g0);
        grab_frame(g2, g1, g0);
        chk("first_259", 32'({g2, g1, g0}), 32'({7'h24, 7'h12, 7'h10}));

        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin step(1, 0, 0); found = frame_done; end
        chk("fd_seen", 32'(found), 32'(1));
        n = 0; found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin step(1, 0, 0); n++; found = frame_done; end
        chk("fd_period", 32'(n), 32'(FRAME));

        foreach (tbl[k]) begin
            step(1, 1, tbl[k].v);
            repeat (2 * FRAME) step(1, 0, 12'h000);
            grab_frame(g2, g1, g0);
            chk($sformatf("tbl_%03h_h", tbl[k].v), 32'(g2), 32'(tbl[k].s2));
            chk($sformatf("tbl_%03h_t", tbl[k].v), 32'(g1), 32'(tbl[k].s1));
            chk($sformatf("tbl_%03h_u", tbl[k].v), 32'(g0), 32'(tbl[k].s0));
        end

        // Two strobes mid-frame: only the later one ever reaches the display.
        repeat (5) step(1, 0, 0);
        step(1, 1, 12'h123);
        step(1, 1, 12'h047);
        repeat (2 * FRAME) step(1, 0, 0);
        grab_frame(g2, g1, g0);
        chk("latest_wins", 32'({g2, g1, g0}), 32'({ZH, 7'h19, 7'h78}));

        // Blank mid-slot, strobe while blank, then re-enable.
        repeat (2) step(1, 0, 0);
        step(0, 0, 0);
        chk("disable_blank", 32'({an, seg, frame_done}), 32'({3'b111, 7'h7F, 1'b0}));
        step(0, 1, 12'h381);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("reenable_d0", 32'({an, seg}), 32'({3'b110, 7'h79}));
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            if (an == 3'b110) n++;
            else break;
        end
        chk("reenable_len", 32'(n), 32'(CLK_DIV));

        // Asynchronous reset between edges.
        repeat (3) step(1, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({an, seg, frame_done}), 32'({3'b111, 7'h7F, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME) step(1, 0, 0);
        grab_frame(g2, g1, g0);
        chk("post_reset_000", 32'({g2, g1, g0}), 32'({ZH, ZH, 7'h40}));

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, 12'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
